dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder at the MEM-stage end of the EX/MEM interface.
- Consumes the load/store request fields the EX/MEM register carries: MemRead, MemWrite, func3, Alu_Result as address, RD_Two as store data.
- Returns aligned, extended load data for the MEM/WB MemReadData field.
- Models a wait-stated synchronous RAM and stalls the pipeline until each access completes.

Parameters:
ADDR_W, 9, byte-address width actually decoded; upper address bits ignored (aliasing).
WAIT_CYCLES, 1, extra busy cycles per access (0..15).
DEPTH, 2**(ADDR_W-2), number of 32-bit words in the array.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  EX/MEM request present this cycle.
mem_read  in  1  load request (EX/MEM MemRead).
mem_write  in  1  store request (EX/MEM MemWrite).
func3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
addr  in  32  byte address (EX/MEM Alu_Result).
wdata  in  32  store data (EX/MEM RD_Two), LSB-aligned.
stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM while high.
rsp_valid  out  1  one-cycle pulse: access complete, rdata/access_err valid.
rdata  out  32  load result, extended per func3; feeds MEM/WB MemReadData.
access_err  out  1  with rsp_valid: misaligned, illegal func3, or read+write both set.

Behaviour:
- Reset values: state IDLE; stall=0, rsp_valid=0, rdata=0, access_err=0, busy counter=0. Memory array is not reset.
- FSM states: IDLE, BUSY, RESP.
- Accept condition: IDLE and req_valid and (mem_read or mem_write). On accept, latch addr, wdata, func3, mem_read, mem_write, counter=0.
- IDLE transitions on accept: to BUSY if WAIT_CYCLES>0, else to RESP.
- IDLE with no accept: stay IDLE; all inputs ignored.
- BUSY: counter increments each cycle. When counter==WAIT_CYCLES-1, go to RESP.
- Array access happens on the edge entering RESP: store performed, load word captured into rdata.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_valid is ignored in RESP, because the pipeline still presents the same request until this edge.
- stall is combinational: (IDLE and accept) or BUSY. stall=0 in RESP and in idle IDLE.
- Latency: one accept cycle + WAIT_CYCLES + one RESP cycle. Back-to-back requests take WAIT_CYCLES+2 cycles each.
- Addressing: word index = addr[ADDR_W-1:2]; lane = addr[1:0]; little-endian.
- Stores:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Other lanes are unchanged (byte enables).
- Loads: select the addressed byte or halfword.
  - func3 000/001: sign-extend.
  - func3 100/101: zero-extend.
  - func3 010: full word.
- Errors (access_err=1 with rsp_valid, rdata=0, no array write, same latency):
  - H access with addr[0]=1.
  - W access with addr[1:0]!=0.
  - func3 in {011,110,111}, or func3 100/101 on a store.
  - mem_read and mem_write both 1.
- Between responses: rdata and access_err hold their last values. access_err is cleared to 0 on the next successful response.
- Reset mid-operation (BUSY or RESP): return to IDLE immediately, outputs to reset values. A pending store not yet performed is dropped; the array is unchanged.
- Uninitialised array words read as X in simulation; the bench must write before read.

Test Plan:
- WAIT_CYCLES=1: SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> stall high 2 cycles per access, rsp_valid 1 cycle, rdata=0xDEADBEEF, access_err=0.
- SB addr 0x22 wdata 0x000000F0 over prior SW 0x20 value 0 -> LW 0x20 returns 0x00F00000; LB 0x22 returns 0xFFFFFFF0; LBU 0x22 returns 0x000000F0.
- SH addr 0x32 wdata 0x8001 -> LH 0x32 returns 0xFFFF8001; LHU 0x32 returns 0x00008001; LW 0x30 lower half unchanged.
- LW addr 0x13 and SH addr 0x11 -> access_err=1, rdata=0, memory at 0x10 still 0xDEADBEEF.
- WAIT_CYCLES=3, LW -> stall high exactly 4 consecutive cycles, rsp_valid on cycle 5, stall low in that cycle; with req_valid held, the next access starts on cycle 6.
- SW 0x40 = 0x12345678 completed; then SW 0x40 = 0xAAAAAAAA with reset asserted during BUSY -> outputs zero asynchronously, FSM IDLE; subsequent LW 0x40 returns 0x12345678.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the EX/MEM pipeline stage and the data-memory responder.
// The pipeline drives the request fields; the responder drives stall and the response fields.
interface dmem_responder_if;
  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        access_err;

  modport master (
    output req_valid, mem_read, mem_write, func3, addr, wdata,
    input  stall, rsp_valid, rdata, access_err
  );

  modport slave (
    input  req_valid, mem_read, mem_write, func3, addr, wdata,
    output stall, rsp_valid, rdata, access_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: accept cycle + WAIT_CYCLES busy + one response cycle.
// Holds the pipeline stalled until the access completes; the array is touched on the edge into RESP.
module dmem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH       = 2 ** (ADDR_W - 2)
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int         IW      = ADDR_W - 2;
  localparam bit         NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] LAST    = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        func3_q, func3_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              mem_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [2:0]        cur_func3;
  logic              cur_rd;
  logic              cur_wr;
  logic              cur_err;
  logic [IW-1:0]     word_idx;
  logic [1:0]        lane;
  logic [31:0]       old_word;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic [31:0]       wmask;
  logic [31:0]       wrep;
  logic [31:0]       new_word;

  // Upper address bits alias onto the decoded range.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W];

  assign accept = (state_q == IDLE) && bus.req_valid && (bus.mem_read || bus.mem_write);

  // With no wait states the array is accessed straight from the live request.
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr  = bus.addr[ADDR_W-1:0];
      cur_wdata = bus.wdata;
      cur_func3 = bus.func3;
      cur_rd    = bus.mem_read;
      cur_wr    = bus.mem_write;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_func3 = func3_q;
      cur_rd    = rd_q;
      cur_wr    = wr_q;
    end
  end

  assign word_idx = cur_addr[ADDR_W-1:2];
  assign lane     = cur_addr[1:0];

  always_comb begin
    cur_err = cur_rd && cur_wr;
    case (cur_func3)
      3'b000:  ;
      3'b001:  if (lane[0]) cur_err = 1'b1;
      3'b010:  if (lane != 2'b00) cur_err = 1'b1;
      3'b100:  if (cur_wr) cur_err = 1'b1;
      3'b101:  if (cur_wr || lane[0]) cur_err = 1'b1;
      default: cur_err = 1'b1;
    endcase
  end

  assign old_word = mem[word_idx];
  assign shifted  = old_word >> {lane, 3'b000};

  always_comb begin
    case (cur_func3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = old_word;
    endcase
  end

  // Replicate store data across lanes, then merge only the enabled bytes.
  always_comb begin
    case (cur_func3[1:0])
      2'b00: begin
        wmask = 32'h0000_00FF << {lane, 3'b000};
        wrep  = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        wmask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wrep  = {2{cur_wdata[15:0]}};
      end
      default: begin
        wmask = 32'hFFFF_FFFF;
        wrep  = cur_wdata;
      end
    endcase
    new_word = (old_word & ~wmask) | (wrep & wmask);
  end

  assign enter_resp = ((state_q == IDLE) && accept && NO_WAIT) ||
                      ((state_q == BUSY) && (cnt_q == LAST));

  // Gating on reset drops a store whose completing edge coincides with reset.
  assign mem_we = enter_resp && cur_wr && !cur_err && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= new_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = NO_WAIT ? RESP : BUSY;
      BUSY:    if (cnt_q == LAST) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall     = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE:    bus.stall = accept;
      BUSY:    bus.stall = 1'b1;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    func3_d = func3_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d   = 4'd0;
      addr_d  = bus.addr[ADDR_W-1:0];
      wdata_d = bus.wdata;
      func3_d = bus.func3;
      rd_d    = bus.mem_read;
      wr_d    = bus.mem_write;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_err || !cur_rd) ? 32'h0 : load_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      func3_q <= 3'b000;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      func3_q <= func3_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.access_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a byte-level memory model.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  logic [7:0] mm [0:511];

  logic [31:0] r, er;
  logic e, ee;
  int nc, ns;

  dmem_responder_if if1();
  dmem_responder_if if3();

  dmem_responder #(.ADDR_W(9), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  dmem_responder #(.ADDR_W(9), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  always #5 clk = ~clk;

  // Reference: memory as bytes, alignment/legality from access size, extension by arithmetic.
  function automatic void model_access(input logic rd, input logic wr, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic [31:0] exp_rd, output logic exp_err);
    int base, sz;
    logic [31:0] v;
    base = int'(a[8:0]);
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    exp_err = (rd && wr) || f3 == 3'd3 || f3 >= 3'd6 || (wr && f3[2]) || (base % sz != 0);
    exp_rd = 32'h0;
    if (!exp_err) begin
      if (wr) begin
        for (int i = 0; i < sz; i++) mm[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mm[base + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        exp_rd = v;
      end
    end
  endfunction

  task automatic acc1(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] got_rd, output logic got_err,
                      output int n_cyc, output int n_stall,
                      output logic [31:0] exp_rd, output logic exp_err);
    bit done;
    if1.req_valid = 1'b1;
    if1.mem_read  = rd;
    if1.mem_write = wr;
    if1.func3     = f3;
    if1.addr      = a;
    if1.wdata     = wd;
    n_cyc = 0;
    n_stall = 0;
    done = 0;
    got_rd = 32'hx;
    got_err = 1'bx;
    while (!done && n_cyc < 40) begin
      @(negedge clk);
      n_cyc++;
      if (if1.stall) n_stall++;
      if (if1.rsp_valid) begin
        done = 1;
        got_rd = if1.rdata;
        got_err = if1.access_err;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rsp_timeout: no rsp_valid within %0d cycles, required one", n_cyc);
    end
    model_access(rd, wr, f3, a, wd, exp_rd, exp_err);
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({if1.stall, if1.rsp_valid, if1.access_err, if1.rdata} !== 35'h0) begin
      errors++;
      $display("FAIL reset_dut1: got %h required 0", {if1.stall, if1.rsp_valid, if1.access_err, if1.rdata});
    end
    checks++;
    if ({if3.stall, if3.rsp_valid, if3.access_err, if3.rdata} !== 35'h0) begin
      errors++;
      $display("FAIL reset_dut3: got %h required 0", {if3.stall, if3.rsp_valid, if3.access_err, if3.rdata});
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word;
    acc1(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r, e, nc, ns, er, ee);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL sw_err: got %b required 0", e); end
    checks++;
    if (nc != 3 || ns != 2) begin errors++; $display("FAIL sw_timing: got %0d cycles %0d stall, required 3/2", nc, ns); end
    acc1(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (r !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL lw_0x10: got %h err %b required deadbeef err 0", r, e); end
    checks++;
    if (nc != 3 || ns != 2) begin errors++; $display("FAIL lw_timing: got %0d cycles %0d stall, required 3/2", nc, ns); end
  endtask

  task automatic test_byte;
    acc1(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, r, e, nc, ns, er, ee);
    acc1(1'b0, 1'b1, 3'b000, 32'h22, 32'h0000_00F0, r, e, nc, ns, er, ee);
    acc1(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (r !== 32'h00F0_0000) begin errors++; $display("FAIL sb_lw: got %h required 00f00000", r); end
    acc1(1'b1, 1'b0, 3'b000, 32'h22, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (r !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb: got %h required fffffff0", r); end
    acc1(1'b1, 1'b0, 3'b100, 32'h22, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (r !== 32'h0000_00F0) begin errors++; $display("FAIL lbu: got %h required 000000f0", r); end
  endtask

  task automatic test_half;
    acc1(1'b0, 1'b1, 3'b010, 32'h30, 32'h0000_CAFE, r, e, nc, ns, er, ee);
    acc1(1'b0, 1'b1, 3'b001, 32'h32, 32'h0000_8001, r, e, nc, ns, er, ee);
    acc1(1'b1, 1'b0, 3'b001, 32'h32, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (r !== 32'hFFFF_8001) begin errors++; $display("FAIL lh: got %h required ffff8001", r); end
    acc1(1'b1, 1'b0, 3'b101, 32'h32, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (r !== 32'h0000_8001) begin errors++; $display("FAIL lhu: got %h required 00008001", r); end
    acc1(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (r !== 32'h8001_CAFE) begin errors++; $display("FAIL sh_lw: got %h required 8001cafe", r); end
  endtask

  task automatic test_errors;
    acc1(1'b1, 1'b0, 3'b010, 32'h13, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (e !== 1'b1 || r !== 32'h0 || nc != 3) begin errors++; $display("FAIL lw_misaligned: got err %b data %h cycles %0d required 1/0/3", e, r, nc); end
    acc1(1'b0, 1'b1, 3'b001, 32'h11, 32'h0000_7777, r, e, nc, ns, er, ee);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL sh_misaligned: got err %b required 1", e); end
    acc1(1'b0, 1'b1, 3'b100, 32'h10, 32'h0000_0011, r, e, nc, ns, er, ee);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL store_unsigned: got err %b required 1", e); end
    acc1(1'b1, 1'b1, 3'b010, 32'h10, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL rd_and_wr: got err %b data %h required 1/0", e, r); end
    acc1(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL func3_011: got err %b required 1", e); end
    acc1(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (r !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL err_no_write: got %h err %b required deadbeef err 0", r, e); end
  endtask

  task automatic test_idle;
    logic seen;
    seen = 1'b0;
    if1.req_valid = 1'b1;
    if1.mem_read  = 1'b0;
    if1.mem_write = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (if1.stall || if1.rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL idle_ignore: got activity %b required 0", seen); end
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0;
  endtask

  task automatic test_random;
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    int sel;
    for (int w = 0; w < 128; w++)
      acc1(1'b0, 1'b1, 3'b010, 32'(w * 4) | ($urandom & 32'hFFFF_FE00), $urandom, r, e, nc, ns, er, ee);
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 9);
      rd = (sel <= 5);
      wr = (sel == 0) || (sel > 5);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
      acc1(rd, wr, f3, a, $urandom, r, e, nc, ns, er, ee);
      checks++;
      if (e !== ee) begin errors++; $display("FAIL rand_err[%0d]: got %b required %b (f3 %b addr %h rd %b wr %b)", k, e, ee, f3, a, rd, wr); end
      if (ee || (rd && !wr)) begin
        checks++;
        if (r !== er) begin errors++; $display("FAIL rand_data[%0d]: got %h required %h (f3 %b addr %h)", k, r, er, f3, a); end
      end
      checks++;
      if (nc != 3 || ns != 2) begin errors++; $display("FAIL rand_timing[%0d]: got %0d cycles %0d stall required 3/2", k, nc, ns); end
    end
  endtask

  task automatic test_wait3;
    logic [5:0] st, rv;
    logic [31:0] rdv;
    int n;
    if3.req_valid = 1'b1;
    if3.mem_read  = 1'b0;
    if3.mem_write = 1'b1;
    if3.func3     = 3'b010;
    if3.addr      = 32'h40;
    if3.wdata     = 32'h5A5A_0F0F;
    n = 0;
    do begin @(negedge clk); n++; end while (!if3.rsp_valid && n < 40);
    checks++;
    if (n != 5) begin errors++; $display("FAIL w3_store_latency: got %0d cycles required 5", n); end
    @(posedge clk);
    #1;
    if3.mem_write = 1'b0;
    if3.mem_read  = 1'b1;
    st = 6'h0;
    rv = 6'h0;
    rdv = 32'h0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      st = {st[4:0], if3.stall};
      rv = {rv[4:0], if3.rsp_valid};
      if (c == 5) rdv = if3.rdata;
    end
    checks++;
    if (st !== 6'b111101) begin errors++; $display("FAIL w3_stall: got %b required 111101", st); end
    checks++;
    if (rv !== 6'b000010) begin errors++; $display("FAIL w3_rsp: got %b required 000010", rv); end
    checks++;
    if (rdv !== 32'h5A5A_0F0F) begin errors++; $display("FAIL w3_data: got %h required 5a5a0f0f", rdv); end
    n = 0;
    do begin @(negedge clk); n++; end while (!if3.rsp_valid && n < 40);
    checks++;
    if (n != 4 || if3.rdata !== 32'h5A5A_0F0F) begin errors++; $display("FAIL w3_second: got %0d cycles data %h required 4/5a5a0f0f", n, if3.rdata); end
    @(posedge clk);
    #1;
    if3.req_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    acc1(1'b0, 1'b1, 3'b010, 32'h40, 32'h1234_5678, r, e, nc, ns, er, ee);
    acc1(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (r !== 32'h1234_5678) begin errors++; $display("FAIL pre_reset_lw: got %h required 12345678", r); end
    if1.req_valid = 1'b1;
    if1.mem_read  = 1'b0;
    if1.mem_write = 1'b1;
    if1.func3     = 3'b010;
    if1.addr      = 32'h40;
    if1.wdata     = 32'hAAAA_AAAA;
    @(posedge clk);
    #2;
    checks++;
    if (if1.stall !== 1'b1) begin errors++; $display("FAIL busy_before_reset: got stall %b required 1", if1.stall); end
    reset = 1'b1;
    if1.req_valid = 1'b0;
    #1;
    checks++;
    if ({if1.stall, if1.rsp_valid, if1.access_err, if1.rdata} !== 35'h0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0", {if1.stall, if1.rsp_valid, if1.access_err, if1.rdata});
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    acc1(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, r, e, nc, ns, er, ee);
    checks++;
    if (r !== 32'h1234_5678 || nc != 3) begin errors++; $display("FAIL post_reset_lw: got %h in %0d cycles required 12345678 in 3", r, nc); end
  endtask

  initial begin
    if1.req_valid = 1'b0; if1.mem_read = 1'b0; if1.mem_write = 1'b0;
    if1.func3 = 3'b000; if1.addr = 32'h0; if1.wdata = 32'h0;
    if3.req_valid = 1'b0; if3.mem_read = 1'b0; if3.mem_write = 1'b0;
    if3.func3 = 3'b000; if3.addr = 32'h0; if3.wdata = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_idle();
    test_wait3();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
